// File: rtl/demux_pkg.sv
// Shared constants, state encoding and decode helper for the round-robin demux scheduler.
package demux_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    ROUTE = 2'd2
  } state_t;

  // Decode a channel number into its one-hot channel vector.
  function automatic logic [NCH-1:0] onehot3to8(input logic [SELW-1:0] s);
    logic [NCH-1:0] v;
    v = NCH'(1) << s;
    return v;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Circular priority finder: picks the first eligible channel after cur_sel,
// wrapping around, with cur_sel itself as the last candidate.
module rr_next_sel
  import demux_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur_sel,
  output logic [SELW-1:0] next_sel,
  output logic            found
);

  logic [SELW-1:0] idx;

  // Walk candidates from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    next_sel = cur_sel;
    idx      = cur_sel;
    for (int i = NCH; i >= 1; i--) begin
      idx = cur_sel + SELW'(i);
      if (mask[idx]) next_sel = idx;
    end
  end

  // Any eligible channel means a grant is possible.
  always_comb begin
    found = |mask;
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler steering one producer stream to eight consumers.
// Each grant lasts up to one burst (or until in_last), separated by one SEEK cycle.
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int DW = 8,
  parameter int BW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NCH-1:0]  chan_mask,
  input  logic [BW-1:0]   burst_len,
  input  logic            in_valid,
  input  logic            in_last,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  input  logic [NCH-1:0]  out_ready,
  output logic [NCH-1:0]  out_valid,
  output logic [DW-1:0]   out_data,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            grant_pulse
);

  // burst_len of zero encodes the largest burst, one past the field's range
  localparam logic [BW:0] MAX_LEN = (BW+1)'(2**BW);
  localparam logic [BW:0] ONE_EXT = (BW+1)'(1);

  state_t          state, state_nxt;
  logic [SELW-1:0] sel_nxt;
  logic [BW-1:0]   beat_cnt, cnt_nxt;
  logic            pulse_nxt;
  logic [SELW-1:0] rr_sel;
  logic            rr_found;
  logic            route;
  logic            xfer;
  logic            burst_done;
  logic [BW:0]     eff_len;

  rr_next_sel u_rr (
    .mask     (chan_mask),
    .cur_sel  (sel),
    .next_sel (rr_sel),
    .found    (rr_found)
  );

  // Handshake gating and burst-boundary detection, all zero latency.
  always_comb begin
    route      = (state == ROUTE);
    xfer       = route && in_valid && out_ready[sel];
    eff_len    = (burst_len == '0) ? MAX_LEN : {1'b0, burst_len};
    burst_done = xfer && (in_last || (({1'b0, beat_cnt} + ONE_EXT) == eff_len));
    in_ready   = route && out_ready[sel];
    out_valid  = onehot3to8(sel) & {NCH{in_valid && route}};
    out_data   = in_data;
    busy       = route;
  end

  // Next-state logic: mask and enable are only consulted in IDLE/SEEK, so a
  // channel losing eligibility mid-burst still finishes its burst.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = beat_cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en && (|chan_mask)) state_nxt = SEEK;
      end
      SEEK: begin
        if (!en || !rr_found) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ROUTE;
          sel_nxt   = rr_sel;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end
      end
      ROUTE: begin
        if (xfer)       cnt_nxt   = beat_cnt + BW'(1);
        if (burst_done) state_nxt = SEEK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; sel parks on 7 so the first search after reset lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '1;
      beat_cnt    <= '0;
      grant_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      beat_cnt    <= cnt_nxt;
      grant_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Randomized scoreboard bench for demux_rr_sched with a beat-level round-robin model.
module tb_demux_rr_sched;

  localparam int DW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [7:0]    chan_mask;
  logic [BW-1:0] burst_len;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    out_ready;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic          busy;
  logic          grant_pulse;

  demux_rr_sched #(.DW(DW), .BW(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .chan_mask   (chan_mask),
    .burst_len   (burst_len),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .sel         (sel),
    .busy        (busy),
    .grant_pulse (grant_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_ch_q[$];
  logic [DW-1:0] exp_d_q[$];
  int model_prev = 7;
  int exp_grants = 0;
  int gp_cnt = 0;
  bit mon_en = 1'b0;
  bit chk_bubble = 1'b0;
  int cyc = 0;
  int last_gp = -1;
  int mon_ec;
  logic [DW-1:0] mon_ed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first eligible channel after prev, prev itself last.
  function automatic int next_chan(input int prev, input logic [7:0] m);
    for (int i = 1; i <= 8; i++) begin
      if (m[(prev + i) % 8]) return (prev + i) % 8;
    end
    return prev;
  endfunction

  function automatic logic [7:0] rand_ready(input int pct);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = ($urandom_range(99) < pct);
    return r;
  endfunction

  // Monitor: compares every accepted beat with the next scoreboard entry.
  always @(negedge clk) begin
    #2;
    if (mon_en && rst_n) begin
      if (grant_pulse) begin
        gp_cnt++;
        check("grant_busy", {31'd0, busy}, 32'd1);
        if (chk_bubble && last_gp >= 0) check("grant_spacing", cyc - last_gp, 32'd3);
        last_gp = cyc;
      end
      if (in_valid && in_ready) begin
        if (exp_ch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got sel %0d data %0h expected no transfer", sel, out_data);
        end else begin
          mon_ec = exp_ch_q.pop_front();
          mon_ed = exp_d_q.pop_front();
          check("xfer_sel", {29'd0, sel}, mon_ec);
          check("xfer_valid", {24'd0, out_valid}, 32'd1 << mon_ec);
          check("xfer_data", {24'd0, out_data}, {24'd0, mon_ed});
        end
      end
    end
  end

  // Build the expected channel of every beat, then drive the beats.
  task automatic run_phase(input int n, input logic [7:0] m1, input logic [7:0] m2, input int sw,
                           input logic [BW-1:0] len, input int vpct, input int rpct,
                           input int lpct, input int last_at);
    logic [DW-1:0] dat[$];
    bit lst[$];
    int cur = -1;
    int cnt = 0;
    int eff;
    int idx = 0;
    int guard = 0;
    logic [7:0] m;
    logic acc;
    eff = (len == 0) ? (1 << BW) : int'(len);
    for (int i = 0; i < n; i++) begin
      dat.push_back(DW'($urandom));
      lst.push_back((i == n - 1) || (i == last_at) || ($urandom_range(99) < lpct));
      m = (i >= sw) ? m2 : m1;
      if (cur < 0) begin
        cur = next_chan(model_prev, m);
        cnt = 0;
        exp_grants++;
      end
      exp_ch_q.push_back(cur);
      exp_d_q.push_back(dat[i]);
      cnt++;
      if (cnt == eff || lst[i]) begin
        model_prev = cur;
        cur = -1;
      end
    end
    burst_len = len;
    chan_mask = m1;
    en = 1'b1;
    while (idx < n && guard < 5000) begin
      @(negedge clk);
      if (idx >= sw) chan_mask = m2;
      in_valid = ($urandom_range(99) < vpct);
      in_data = dat[idx];
      in_last = lst[idx];
      out_ready = rand_ready(rpct);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    if (idx < n) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: got %0d beats expected %0d", idx, n);
      exp_ch_q.delete();
      exp_d_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("grant_count", gp_cnt, exp_grants);
    check("queue_empty", exp_ch_q.size(), 32'd0);
  endtask

  task automatic wait_busy(input string name);
    int t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(name, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] m1, m2;
    rst_n = 1'b0;
    en = 1'b0;
    chan_mask = 8'h00;
    burst_len = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sel", {29'd0, sel}, 32'd7);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {24'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_pulse", {31'd0, grant_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Full mask, 2-beat bursts, continuous traffic: 0..7,0 with 3-cycle grant period.
    chk_bubble = 1'b1;
    last_gp = -1;
    run_phase(18, 8'hFF, 8'hFF, 1000, 4'd2, 100, 100, 0, -1);
    chk_bubble = 1'b0;

    // Two eligible channels, single beats: alternate 2 and 7.
    run_phase(8, 8'h84, 8'h84, 1000, 4'd1, 100, 100, 0, -1);

    // in_last on second beat to ch0 cuts a 4-beat burst short; ch1 follows.
    run_phase(4, 8'hFF, 8'hFF, 1000, 4'd4, 100, 100, 0, 1);

    // ch3 granted but its consumer stalls for 5 cycles.
    chan_mask = 8'h08;
    burst_len = 4'd4;
    out_ready = 8'hF7;
    in_valid = 1'b1;
    en = 1'b1;
    wait_busy("stall_grant");
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {24'd0, out_valid}, 32'h08);
      @(negedge clk);
      #1;
    end
    run_phase(4, 8'h08, 8'h08, 1000, 4'd4, 100, 100, 0, -1);

    // ch5 loses eligibility after its first beat but completes 3 beats.
    run_phase(6, 8'h21, 8'h01, 1, 4'd3, 100, 100, 0, -1);

    // burst_len 0 gives 16-beat bursts; sole channel is reselected.
    run_phase(32, 8'h02, 8'h02, 1000, 4'd0, 100, 100, 0, -1);

    // Randomized traffic, masks, burst lengths and mid-phase mask changes.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(10, 40);
      m1 = 8'($urandom_range(1, 255));
      m2 = (r % 2 == 1) ? 8'($urandom_range(1, 255)) : m1;
      run_phase(n, m1, m2, (r % 2 == 1) ? $urandom_range(1, n - 1) : 1000,
                BW'($urandom_range(0, 15)), $urandom_range(60, 100),
                $urandom_range(50, 100), 10, -1);
    end

    // Asynchronous reset in the middle of a ch4 burst.
    mon_en = 1'b0;
    chan_mask = 8'h10;
    burst_len = 4'd4;
    out_ready = 8'hFF;
    in_valid = 1'b0;
    en = 1'b1;
    wait_busy("rst_mid_grant");
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("pre_rst_out_valid", {24'd0, out_valid}, 32'h10);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {24'd0, out_valid}, 32'd0);
    check("mid_rst_sel", {29'd0, sel}, 32'd7);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_prev = 7;
    gp_cnt = 0;
    exp_grants = 0;
    exp_ch_q.delete();
    exp_d_q.delete();
    mon_en = 1'b1;
    run_phase(6, 8'hFF, 8'hFF, 1000, 4'd3, 100, 100, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
